// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch sequencer for the 8-bit CPU.
//   Owns the program counter and drives the address and read strobe toward
//   memory. Each instruction byte takes two cycles: F_x presents the address,
//   and L_x samples mem_data at its closing edge. An instruction is 1 byte
//   when opcode bit7=0, or 3 bytes (opcode, operand lo, operand hi) when
//   bit7=1. The assembled instruction is held in DONE until instr_ack.
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   cpustate          fetching only proceeds while equal to RUN_STATE
//   fetch_req         level request to fetch the next instruction
//   pc_load, pc_in    jump: honoured in IDLE and DONE only
//   mem_data          memory read data
//   instr_ack         execute stage consumed opcode/operand
//   addr, read        memory address (always pc) and read strobe
//   opcode, operand   assembled instruction (operand 0 for 1-byte)
//   instr_valid       instruction held and valid (DONE)
//   busy, pc          not-IDLE flag, program counter
module fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [1:0]  RUN_STATE = 2'b11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  cpustate,
  input  logic        fetch_req,
  input  logic        pc_load,
  input  logic [15:0] pc_in,
  input  logic [7:0]  mem_data,
  input  logic        instr_ack,
  output logic [15:0] addr,
  output logic        read,
  output logic [7:0]  opcode,
  output logic [15:0] operand,
  output logic        instr_valid,
  output logic        busy,
  output logic [15:0] pc
);

  typedef enum logic [2:0] {
    IDLE, F_OP, L_OP, F_LO, L_LO, F_HI, L_HI, DONE
  } state_t;

  state_t state, state_n;
  logic   run;

  assign run = (cpustate == RUN_STATE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (fetch_req && run) state_n = F_OP;
      F_OP: state_n = L_OP;
      // mem_data here is the opcode being latched this edge
      L_OP: state_n = mem_data[7] ? F_LO : DONE;
      F_LO: state_n = L_LO;
      L_LO: state_n = F_HI;
      F_HI: state_n = L_HI;
      L_HI: state_n = DONE;
      DONE: if (instr_ack) state_n = fetch_req ? F_OP : IDLE;
      default: state_n = IDLE;
    endcase
    // leaving RUN abandons whatever is in flight
    if (state != IDLE && !run) state_n = IDLE;
  end

  // Datapath: captures are gated by run so an abort edge applies no
  // further pc increment and leaves opcode/operand untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= RESET_PC;
      opcode  <= 8'h00;
      operand <= 16'h0000;
    end else begin
      if ((state == IDLE || state == DONE) && pc_load) pc <= pc_in;
      if (run) begin
        unique case (state)
          L_OP: begin
            opcode  <= mem_data;
            operand <= 16'h0000;
            pc      <= pc + 16'd1;
          end
          L_LO: begin
            operand[7:0] <= mem_data;
            pc           <= pc + 16'd1;
          end
          L_HI: begin
            operand[15:8] <= mem_data;
            pc            <= pc + 16'd1;
          end
          default: ;
        endcase
      end
    end
  end

  // addr follows pc in every state; a load in IDLE is visible in F_OP.
  assign addr        = pc;
  assign read        = run && (state inside {F_OP, L_OP, F_LO, L_LO, F_HI, L_HI});
  assign instr_valid = (state == DONE);
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized single fetches,
// checked against an instruction-level model (byte memory + pc arithmetic).
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  cpustate;
  logic        fetch_req, pc_load, instr_ack;
  logic [15:0] pc_in;
  logic [7:0]  mem_data;
  logic [15:0] addr, operand, pc;
  logic        read, instr_valid, busy;
  logic [7:0]  opcode;

  logic [7:0] mem [0:65535];
  int total = 0;
  int bad   = 0;

  fetch_unit dut (
    .clk(clk), .reset(reset), .cpustate(cpustate), .fetch_req(fetch_req),
    .pc_load(pc_load), .pc_in(pc_in), .mem_data(mem_data),
    .instr_ack(instr_ack), .addr(addr), .read(read), .opcode(opcode),
    .operand(operand), .instr_valid(instr_valid), .busy(busy), .pc(pc)
  );

  always #5 clk = ~clk;

  // synchronous memory read port: data for addr appears after the edge
  always @(posedge clk) mem_data <= mem[addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // wait for instr_valid, counting cycles; lat=99 on timeout
  task automatic wait_valid(input bit hold, output int lat);
    lat = 99;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) begin
        pc_load = 1'b0;
        if (!hold) fetch_req = 1'b0;
      end
      if (instr_valid) begin lat = c; break; end
    end
  endtask

  task automatic start_fetch(input bit load, input logic [15:0] tgt, input bit hold, output int lat);
    pc_load   = load;
    pc_in     = tgt;
    fetch_req = 1'b1;
    wait_valid(hold, lat);
  endtask

  task automatic ack_idle();
    fetch_req = 1'b0;
    instr_ack = 1'b1;
    @(negedge clk);
    instr_ack = 1'b0;
    chk("ack_to_idle", {instr_valid, busy}, 2'b00);
  endtask

  initial begin
    int lat;
    logic [15:0] sp, ep, eop;
    logic [7:0]  eopc;
    int          len;

    foreach (mem[i]) mem[i] = 8'h00;
    reset = 1'b1; cpustate = 2'b11; fetch_req = 0; pc_load = 0;
    pc_in = 16'h0; instr_ack = 0;
    repeat (2) @(negedge clk);

    // reset values
    chk("rst_pc", pc, 16'h0000);
    chk("rst_addr", addr, 16'h0000);
    chk("rst_read", read, 1'b0);
    chk("rst_opcode", opcode, 8'h00);
    chk("rst_operand", operand, 16'h0000);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    reset = 1'b0;

    // 1-byte instruction at 0, read strobe over two cycles
    mem[0] = 8'h12;
    fetch_req = 1'b1;
    @(negedge clk); fetch_req = 1'b0;
    chk("t1_read_c1", {read, addr}, {1'b1, 16'h0000});
    @(negedge clk);
    chk("t1_read_c2", {read, addr}, {1'b1, 16'h0000});
    @(negedge clk);
    chk("t1_valid_c3", instr_valid, 1'b1);
    chk("t1_read_done", read, 1'b0);
    chk("t1_opcode", opcode, 8'h12);
    chk("t1_operand", operand, 16'h0000);
    chk("t1_pc", pc, 16'h0001);
    ack_idle();

    // 3-byte instruction via jump + fetch
    mem[4] = 8'h85; mem[5] = 8'h34; mem[6] = 8'h12;
    start_fetch(1, 16'h0004, 0, lat);
    chk("t2_lat", lat, 7);
    chk("t2_opcode", opcode, 8'h85);
    chk("t2_operand", operand, 16'h1234);
    chk("t2_pc", pc, 16'h0007);
    ack_idle();

    // back-to-back 1-byte fetches at 0,1,2
    mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03;
    start_fetch(1, 16'h0000, 1, lat);
    chk("t3_lat0", lat, 3);
    for (int k = 0; k < 3; k++) begin
      chk("t3_opcode", opcode, 8'(k + 1));
      if (k == 2) begin
        ack_idle();
      end else begin
        instr_ack = 1'b1;
        @(negedge clk);
        instr_ack = 1'b0;
        chk("t3_no_idle", {busy, read, instr_valid, addr}, {3'b110, 16'(k + 1)});
        wait_valid(1, lat);
        chk("t3_lat", lat, 2);
      end
    end

    // jump together with ack in DONE
    mem[0] = 8'h01; mem[16'h20] = 8'h33;
    start_fetch(1, 16'h0000, 1, lat);
    pc_load = 1'b1; pc_in = 16'h0020; instr_ack = 1'b1;
    @(negedge clk);
    pc_load = 1'b0; instr_ack = 1'b0; fetch_req = 1'b0;
    chk("t4_addr", {read, addr}, {1'b1, 16'h0020});
    wait_valid(0, lat);
    chk("t4_lat", lat, 2);
    chk("t4_opcode", opcode, 8'h33);
    chk("t4_pc", pc, 16'h0021);
    // pc_load in DONE without ack: pc moves, outputs hold
    pc_load = 1'b1; pc_in = 16'h1234;
    @(negedge clk);
    pc_load = 1'b0;
    chk("t5_pc", pc, 16'h1234);
    chk("t5_hold", {instr_valid, opcode}, {1'b1, 8'h33});
    ack_idle();

    // pc wrap inside a 3-byte instruction
    mem[16'hFFFF] = 8'h9A; mem[0] = 8'h11; mem[1] = 8'h22;
    start_fetch(1, 16'hFFFF, 0, lat);
    chk("t6_lat", lat, 7);
    chk("t6_operand", operand, 16'h2211);
    chk("t6_pc", pc, 16'h0002);
    ack_idle();

    // cpustate leaves RUN during L_LO
    mem[16'h100] = 8'h80;
    pc_load = 1'b1; pc_in = 16'h0100; fetch_req = 1'b1;
    @(negedge clk); pc_load = 1'b0; fetch_req = 1'b0;   // F_OP
    repeat (3) @(negedge clk);                          // L_OP, F_LO, L_LO
    chk("t7_in_llo", {busy, read, pc}, {2'b11, 16'h0101});
    cpustate = 2'b10;
    #1 chk("t7_read_gated", read, 1'b0);
    @(negedge clk);
    chk("t7_abort", {busy, read, instr_valid}, 3'b000);
    chk("t7_pc", pc, 16'h0101);
    chk("t7_opcode", opcode, 8'h80);
    cpustate = 2'b11;

    // reset mid-fetch
    pc_load = 1'b1; pc_in = 16'h0040; fetch_req = 1'b1;
    mem[16'h40] = 8'hC0;
    @(negedge clk); pc_load = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1; fetch_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("t8_rst", {pc, addr, read, opcode, operand, instr_valid, busy},
        {16'h0000, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0});

    // random single fetches against the instruction-level model
    for (int n = 0; n < 40; n++) begin
      sp = 16'($urandom);
      if (n < 4) sp = 16'hFFFE - 16'(n);   // force some wrap cases
      mem[sp]         = 8'($urandom);
      mem[16'(sp + 1)] = 8'($urandom);
      mem[16'(sp + 2)] = 8'($urandom);
      eopc = mem[sp];
      len  = eopc[7] ? 3 : 1;
      eop  = (len == 3) ? {mem[16'(sp + 2)], mem[16'(sp + 1)]} : 16'h0000;
      ep   = 16'(sp + 16'(len));
      start_fetch(1, sp, 0, lat);
      chk("rnd_lat", lat, 2 * len + 1);
      chk("rnd_opcode", opcode, eopc);
      chk("rnd_operand", operand, eop);
      chk("rnd_pc", pc, ep);
      ack_idle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
